seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter GUARD, default 2, anode-off cycles at start of each slot (0..CLK_DIV-1).
REQ-004 SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period (>=1).
REQ-005 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port digits  input  5*N_DIGITS  packed 5-bit digit codes; slice 0 = least significant digit.
REQ-008 SHALL have port load  input  1  strobe: capture digits into shadow register.
REQ-009 SHALL have port lzs  input  1  leading-zero suppression enable.
REQ-010 SHALL have port blink_mask  input  N_DIGITS  per-digit blink enable.
REQ-011 SHALL have port seg  output  7  registered segments {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-012 SHALL have port an  output  N_DIGITS  registered one-hot anode select, active-low.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-014 Codes SHALL decode: 0..9 -> standard digits ("0" = 1000000, "1" = 1111001, "8" = 0000000), 10 -> blank 1111111, 11 -> dash 0111111, 12..31 -> blank.
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap; at terminal count, digit index SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-016 frame_done SHALL assert for exactly the one cycle following the index wrap N_DIGITS-1 -> 0.
REQ-017 load=1 at a clock edge SHALL capture digits into shadow; load SHALL take effect on the display only at the next frame wrap (tear-free).
REQ-018 At a frame wrap, active register SHALL take the pre-edge shadow value; a load in the same cycle SHALL update shadow and appear one frame later.
REQ-019 seg and an SHALL reflect the new index one cycle after the index change (one-cycle registered latency).
REQ-020 During the first GUARD cycles of each slot, an SHALL be all ones; seg SHALL already show the slot's digit.
REQ-021 With lzs=1, code-0 digits more significant than the highest non-zero digit SHALL display blank; digit 0 SHALL never be suppressed; codes 10..31 count as non-zero.
REQ-022 Blink phase SHALL toggle every BLINK_FRAMES frame wraps; in off phase, digits with blink_mask bit set SHALL display blank; an SHALL still scan.
REQ-023 lzs and blink_mask SHALL be sampled live each slot, not shadowed.
REQ-024 N_DIGITS=1 SHALL be legal: index constant 0, frame_done pulses every CLK_DIV cycles.

Reset
REQ-025 rst_n low SHALL asynchronously set: prescaler 0, index 0, shadow and active all code 10, seg 1111111, an all ones, frame_done 0, blink phase on, blink counter 0.
REQ-026 Reset assertion mid-slot SHALL blank outputs immediately; after deassertion, first slot SHALL start at index 0 with full GUARD.

Structure
REQ-027 Package seg_pkg SHALL hold code constants (BLANK=10, DASH=11), 7-bit segment pattern constants, and the 5-bit code width.
REQ-028 Sub-module seg7_decode (combinational 5-bit code -> 7-bit active-low pattern) SHALL be instantiated once on the muxed digit.
REQ-029 Counter widths SHALL derive from $clog2 of parameters; no hard-coded widths.

Verification (N_DIGITS=4, CLK_DIV=4, GUARD=1, BLINK_FRAMES=2)
REQ-030 Reset release, no load -> seg=1111111 throughout, an cycles 1110,1101,1011,0111 each held 3 cycles after 1-cycle 1111 guard; frame_done every 16 cycles.
REQ-031 load digits={3,2,1,0} mid-frame -> display unchanged until next frame_done, then slot 0 seg=1000000, slot 3 seg=0110000.
REQ-032 digits={0,0,4,0}, lzs=1 -> slots 3,2 blank, slot 1 seg=0011001, slot 0 seg=1000000; lzs=0 -> slots 3,2 show 1000000.
REQ-033 blink_mask=0001, digit0=8 -> slot 0 seg=0000000 for 2 frames, 1111111 for 2 frames, repeating; other slots unaffected.
REQ-034 load coincident with frame wrap -> old shadow shown next frame, new value the frame after.
REQ-035 rst_n pulsed low mid-slot 2 -> outputs blank same cycle; after release, scan restarts at an=1111 then 1110.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the multiplexed seven-segment scanner.
//   CODE_W     : width of one digit code
//   BLANK/DASH : special digit codes
//   SEG_*      : active-low segment patterns ordered {g,f,e,d,c,b,a}
package seg_pkg;

  localparam int CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [6:0]        seg_t;

  localparam code_t BLANK = 5'd10;
  localparam code_t DASH  = 5'd11;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational digit-code to segment-pattern decoder.
//   i_code : 5-bit digit code (0..9 digits, 11 dash, everything else blank)
//   o_seg  : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import seg_pkg::*;
(
  input  code_t i_code,
  output seg_t  o_seg
);

  // Pure lookup; every code outside 0..9 and DASH shows nothing.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      5'd0:    o_seg = SEG_0;
      5'd1:    o_seg = SEG_1;
      5'd2:    o_seg = SEG_2;
      5'd3:    o_seg = SEG_3;
      5'd4:    o_seg = SEG_4;
      5'd5:    o_seg = SEG_5;
      5'd6:    o_seg = SEG_6;
      5'd7:    o_seg = SEG_7;
      5'd8:    o_seg = SEG_8;
      5'd9:    o_seg = SEG_9;
      DASH:    o_seg = SEG_DASH;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display
// Time-multiplexed driver for N_DIGITS seven-segment digits with tear-free
// loading, leading-zero suppression, per-digit blinking and anode guard time.
//   clk, rst_n  : clock, asynchronous active-low reset
//   digits      : packed 5-bit codes, slice 0 = least significant digit
//   load        : capture digits into the shadow register
//   lzs         : leading-zero suppression enable (live)
//   blink_mask  : per-digit blink enable (live)
//   seg         : registered active-low segments {g,f,e,d,c,b,a}
//   an          : registered active-low one-hot anode select
//   frame_done  : one-cycle pulse after each frame wrap
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CODE_W*N_DIGITS-1:0] digits,
  input  logic                       load,
  input  logic                       lzs,
  input  logic [N_DIGITS-1:0]        blink_mask,
  output logic [6:0]                 seg,
  output logic [N_DIGITS-1:0]        an,
  output logic                       frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]              r_presc;
  logic [IW-1:0]              r_idx;
  logic [CODE_W*N_DIGITS-1:0] r_shadow;
  logic [CODE_W*N_DIGITS-1:0] r_active;
  logic [BW-1:0]              r_blink_cnt;
  logic                       r_blink_on;
  logic [6:0]                 r_seg;
  logic [N_DIGITS-1:0]        r_an;
  logic                       r_frame_done;

  logic                w_slot_end;
  logic                w_frame_wrap;
  code_t               w_code_raw;
  logic                w_nz_at_or_above;
  logic                w_blink_sel;
  code_t               w_code;
  seg_t                w_seg;
  logic [N_DIGITS-1:0] w_an;

  assign w_slot_end   = (r_presc == PRESC_LAST);
  assign w_frame_wrap = w_slot_end && (r_idx == IDX_LAST);

  // Prescaler and digit index. frame_done is registered off the wrap so it
  // is high during the first cycle of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_wrap;
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Double buffering: the displayed digits only change at a frame wrap, and
  // they take the shadow value from before a simultaneous load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= {N_DIGITS{BLANK}};
      r_active <= {N_DIGITS{BLANK}};
    end else begin
      if (load) begin
        r_shadow <= digits;
      end
      if (w_frame_wrap) begin
        r_active <= r_shadow;
      end
    end
  end

  // Blink phase flips once every BLINK_FRAMES frame wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Select the current digit. A digit is a suppressible leading zero when it
  // and every more significant digit hold code 0; digit 0 is always shown.
  always_comb begin
    w_code_raw       = BLANK;
    w_nz_at_or_above = 1'b0;
    w_blink_sel      = 1'b0;
    w_an             = '1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (r_idx == IW'(j)) begin
        w_code_raw  = r_active[j*CODE_W +: CODE_W];
        w_blink_sel = blink_mask[j];
        if (r_presc >= GUARD_END) begin
          w_an[j] = 1'b0;
        end
      end
      if ((IW'(j) >= r_idx) && (r_active[j*CODE_W +: CODE_W] != '0)) begin
        w_nz_at_or_above = 1'b1;
      end
    end
    w_code = w_code_raw;
    if (lzs && (r_idx != '0) && !w_nz_at_or_above) begin
      w_code = BLANK;
    end
    if (!r_blink_on && w_blink_sel) begin
      w_code = BLANK;
    end
  end

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Registered pin drivers, one cycle behind the index/prescaler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
// Self-checking bench for seg_scan_display (4 digits, 4-cycle slots, 1-cycle
// guard, 2-frame blink). A time-based reference model predicts seg/an/
// frame_done every cycle; literal checks pin key display values.
module tb_seg_scan_display;

  localparam int NDIG   = 4;
  localparam int CDIV   = 4;
  localparam int GRD    = 1;
  localparam int BLINK  = 2;
  localparam int FRAME  = NDIG * CDIV;

  logic        clk;
  logic        rst_n;
  logic [19:0] digits;
  logic        load;
  logic        lzs;
  logic [3:0]  blinkMask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frameDone;

  int assertCount = 0;
  int failCount   = 0;
  logic checkEn = 1'b0;

  int          edgeCount;
  logic [19:0] modelShadow;
  logic [19:0] modelActive;
  logic [6:0]  expSeg;
  logic [3:0]  expAn;
  logic        expFd;

  seg_scan_display #(
    .N_DIGITS     (NDIG),
    .CLK_DIV      (CDIV),
    .GUARD        (GRD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .load       (load),
    .lzs        (lzs),
    .blink_mask (blinkMask),
    .seg        (seg),
    .an         (an),
    .frame_done (frameDone)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Segment patterns for each code, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] segOf(input logic [4:0] code);
    case (code)
      5'd0:    return 7'b1000000;
      5'd1:    return 7'b1111001;
      5'd2:    return 7'b0100100;
      5'd3:    return 7'b0110000;
      5'd4:    return 7'b0011001;
      5'd5:    return 7'b0010010;
      5'd6:    return 7'b0000010;
      5'd7:    return 7'b1111000;
      5'd8:    return 7'b0000000;
      5'd9:    return 7'b0010000;
      5'd11:   return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for the state c cycles after reset release, derived
  // from slot arithmetic, the current display buffer and the live inputs.
  function automatic logic [6:0] modelSeg(input int c, input logic [19:0] act,
                                          input logic lz, input logic [3:0] mask);
    int slot;
    int wraps;
    int highest;
    logic [4:0] code;
    slot    = (c / CDIV) % NDIG;
    wraps   = c / FRAME;
    highest = -1;
    for (int i = 0; i < NDIG; i++) begin
      if (act[i*5 +: 5] != 5'd0) highest = i;
    end
    code = act[slot*5 +: 5];
    if (lz && slot > 0 && slot > highest) code = 5'd10;
    if (((wraps / BLINK) % 2) == 1 && mask[slot]) code = 5'd10;
    return segOf(code);
  endfunction

  function automatic logic [3:0] modelAn(input int c);
    if ((c % CDIV) < GRD) return 4'b1111;
    return ~(4'b0001 << ((c / CDIV) % NDIG));
  endfunction

  // Reference model: outputs after each edge reflect the state that existed
  // before it; the display buffer takes the shadow at every 16th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeCount   <= 0;
      modelShadow <= {NDIG{5'd10}};
      modelActive <= {NDIG{5'd10}};
      expSeg      <= 7'b1111111;
      expAn       <= 4'b1111;
      expFd       <= 1'b0;
    end else begin
      expSeg <= modelSeg(edgeCount, modelActive, lzs, blinkMask);
      expAn  <= modelAn(edgeCount);
      expFd  <= ((edgeCount + 1) % FRAME) == 0;
      if (((edgeCount + 1) % FRAME) == 0) modelActive <= modelShadow;
      if (load) modelShadow <= digits;
      edgeCount <= edgeCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("modelSeg", seg, expSeg);
      checkOutput("modelAn", an, expAn);
      checkOutput("modelFrameDone", frameDone, expFd);
    end
  end

  task automatic applyStimulus(input logic [19:0] d, input logic l,
                               input logic z, input logic [3:0] m);
    digits    = d;
    load      = l;
    lzs       = z;
    blinkMask = m;
    @(negedge clk);
  endtask

  task automatic boundFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  task automatic waitFd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameDone && n < 40);
    if (!frameDone) boundFail(name);
  endtask

  task automatic waitAn(input logic [3:0] target, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 40);
    if (an !== target) boundFail(name);
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic checkLit(input string name, input logic [6:0] expected);
    checkOutput(name, seg, expected);
    checkOutput({name, "Model"}, expSeg, expected);
  endtask

  logic [19:0] randDigits;
  logic        randLzs;
  logic [3:0]  randMask;
  int          period;
  logic [6:0]  blinkExp [5];

  initial begin
    rst_n     = 1'b0;
    digits    = '0;
    load      = 1'b0;
    lzs       = 1'b0;
    blinkMask = 4'b0000;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetSeg", seg, 7'b1111111);
    checkOutput("resetAn", an, 4'b1111);
    checkOutput("resetFd", frameDone, 1'b0);

    // Release reset: guard cycle first, then slot 0, blank digits.
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("firstGuardAn", an, 4'b1111);
    @(negedge clk);
    checkOutput("firstSlotAn", an, 4'b1110);
    checkOutput("blankSeg", seg, 7'b1111111);
    waitFd("firstFrameDone");
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (!frameDone && period < 40);
    checkOutput("fdPeriod", period, 16);

    // Mid-frame load is invisible until the next wrap.
    repeat (5) @(negedge clk);
    applyStimulus({5'd3, 5'd2, 5'd1, 5'd0}, 1'b1, 1'b0, 4'b0000);
    applyStimulus({5'd3, 5'd2, 5'd1, 5'd0}, 1'b0, 1'b0, 4'b0000);
    waitAn(4'b0111, "waitSlot3Old");
    checkLit("slot3BeforeWrap", 7'b1111111);
    waitFd("loadFrameDone");
    waitAn(4'b1110, "waitSlot0New");
    checkLit("slot0Zero", 7'b1000000);
    waitAn(4'b0111, "waitSlot3New");
    checkLit("slot3Three", 7'b0110000);

    // Leading-zero suppression on {0,0,4,0}.
    applyStimulus({5'd0, 5'd0, 5'd4, 5'd0}, 1'b1, 1'b1, 4'b0000);
    applyStimulus({5'd0, 5'd0, 5'd4, 5'd0}, 1'b0, 1'b1, 4'b0000);
    waitFd("lzsFrameDone");
    waitAn(4'b1110, "lzsSlot0");
    checkLit("lzsSlot0", 7'b1000000);
    waitAn(4'b1101, "lzsSlot1");
    checkLit("lzsSlot1", 7'b0011001);
    waitAn(4'b1011, "lzsSlot2");
    checkLit("lzsSlot2", 7'b1111111);
    waitAn(4'b0111, "lzsSlot3");
    checkLit("lzsSlot3", 7'b1111111);
    applyStimulus({5'd0, 5'd0, 5'd4, 5'd0}, 1'b0, 1'b0, 4'b0000);
    waitAn(4'b1011, "noLzsSlot2");
    checkLit("noLzsSlot2", 7'b1000000);
    waitAn(4'b0111, "noLzsSlot3");
    checkLit("noLzsSlot3", 7'b1000000);

    // Load coincident with the wrap: old shadow next frame, new one after.
    waitFd("coincidentAlign");
    applyStimulus({4{5'd2}}, 1'b1, 1'b0, 4'b0000);
    repeat (14) applyStimulus({4{5'd2}}, 1'b0, 1'b0, 4'b0000);
    applyStimulus({4{5'd5}}, 1'b1, 1'b0, 4'b0000);
    checkOutput("coincidentFd", frameDone, 1'b1);
    applyStimulus({4{5'd5}}, 1'b0, 1'b0, 4'b0000);
    waitAn(4'b1110, "coincidentOld");
    checkLit("coincidentOld", 7'b0100100);
    waitFd("coincidentNextFrame");
    waitAn(4'b1110, "coincidentNew");
    checkLit("coincidentNew", 7'b0010010);

    // Asynchronous reset in the middle of slot 2.
    waitAn(4'b1011, "resetSlot2");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstSeg", seg, 7'b1111111);
    checkOutput("asyncRstAn", an, 4'b1111);
    checkOutput("asyncRstFd", frameDone, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus({5'd1, 5'd1, 5'd1, 5'd8}, 1'b1, 1'b0, 4'b0001);
    checkOutput("restartGuardAn", an, 4'b1111);
    applyStimulus({5'd1, 5'd1, 5'd1, 5'd8}, 1'b0, 1'b0, 4'b0001);
    checkOutput("restartSlot0An", an, 4'b1110);

    // Blink on slot 0: frame 0 counts as "on", so frames 1 on, 2-3 off, 4-5 on.
    blinkExp = '{7'b0000000, 7'b1111111, 7'b1111111, 7'b0000000, 7'b0000000};
    for (int f = 0; f < 5; f++) begin
      waitFd("blinkFrameDone");
      waitAn(4'b1110, "blinkSlot0");
      checkLit("blinkSlot0", blinkExp[f]);
      if (f == 1) begin
        waitAn(4'b1101, "blinkSlot1");
        checkLit("blinkOtherSlot", 7'b1111001);
      end
    end

    // Randomized traffic checked by the model.
    randLzs  = 1'b0;
    randMask = 4'b0000;
    repeat (1500) begin
      for (int i = 0; i < NDIG; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      randDigits[i*5 +: 5] = 5'd0;
        else if (r < 8) randDigits[i*5 +: 5] = 5'($urandom_range(1, 9));
        else            randDigits[i*5 +: 5] = 5'($urandom_range(10, 31));
      end
      if ($urandom_range(0, 49) == 0) randLzs = ~randLzs;
      if ($urandom_range(0, 99) == 0) randMask = 4'($urandom_range(0, 15));
      applyStimulus(randDigits, ($urandom_range(0, 9) == 0), randLzs, randMask);
    end

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
